// File: rtl/mod10_counter_arbiter.sv
// Round-robin command arbiter sharing one external mod-10 counter between NUM_REQ requesters.
// Sequences the counter's mode/load/data_in pins and returns the resulting count to the granted requester.
module mod10_counter_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int STEP_W  = 8
) (
    input  logic                        clock,
    input  logic                        rst,
    input  logic [NUM_REQ-1:0]          req,
    input  logic [2*NUM_REQ-1:0]        req_op,
    input  logic [4*NUM_REQ-1:0]        req_val,
    input  logic [STEP_W*NUM_REQ-1:0]   req_steps,
    output logic [NUM_REQ-1:0]          gnt,
    output logic                        busy,
    output logic                        done,
    output logic [2:0]                  done_id,
    output logic [3:0]                  result,
    output logic                        err,
    output logic                        cnt_mode,
    output logic                        cnt_load,
    output logic [3:0]                  cnt_data_in,
    input  logic [3:0]                  cnt_data_out
);

    typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, DONE = 2'd2} state_t;

    localparam logic [1:0] OP_LOAD = 2'b00;
    localparam logic [1:0] OP_UP   = 2'b01;
    localparam logic [1:0] OP_READ = 2'b11;

    state_t              state_q;
    logic [2:0]          last_q;
    logic [2:0]          id_q;
    logic [1:0]          op_q;
    logic [3:0]          val_q;
    logic [STEP_W-1:0]   rem_q;
    logic                err_q;

    logic                found_s;
    logic [2:0]          win_s;
    logic [1:0]          op_sel_s;
    logic [3:0]          val_sel_s;
    logic [STEP_W-1:0]   steps_sel_s;

    // Rotating priority search starting at the requester after the last grant
    always_comb begin
        found_s     = 1'b0;
        win_s       = 3'd0;
        op_sel_s    = 2'b00;
        val_sel_s   = 4'd0;
        steps_sel_s = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!found_s && req[i] && (((int'(last_q) + k) % NUM_REQ) == i)) begin
                    found_s     = 1'b1;
                    win_s       = i[2:0];
                    op_sel_s    = req_op[2*i +: 2];
                    val_sel_s   = req_val[4*i +: 4];
                    steps_sel_s = req_steps[STEP_W*i +: STEP_W];
                end else begin
                    found_s = found_s;
                end
            end
        end
    end

    // Grant is combinational in IDLE and forced low while reset is held
    always_comb begin
        gnt = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (rst && (state_q == IDLE) && found_s && (win_s == i[2:0])) begin
                gnt[i] = 1'b1;
            end else begin
                gnt[i] = 1'b0;
            end
        end
    end

    // Command FSM: capture payload on grant, run the counter, report once
    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            last_q  <= 3'(NUM_REQ - 1);
            id_q    <= 3'd0;
            op_q    <= 2'b00;
            val_q   <= 4'd0;
            rem_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (found_s) begin
                        last_q <= win_s;
                        id_q   <= win_s;
                        op_q   <= op_sel_s;
                        val_q  <= val_sel_s;
                        rem_q  <= steps_sel_s;
                        err_q  <= (op_sel_s == OP_LOAD) && (val_sel_s > 4'd9);
                        if (op_sel_s == OP_LOAD) begin
                            state_q <= (val_sel_s > 4'd9) ? DONE : EXEC;
                        end else if ((op_sel_s == OP_READ) || (steps_sel_s == '0)) begin
                            state_q <= DONE;
                        end else begin
                            state_q <= EXEC;
                        end
                    end else begin
                        state_q <= IDLE;
                    end
                end
                EXEC: begin
                    if (op_q == OP_LOAD) begin
                        state_q <= DONE;
                    end else begin
                        rem_q <= rem_q - STEP_W'(1);
                        // rem_q never reaches EXEC as zero; <= guards a corrupted value
                        if (rem_q <= STEP_W'(1)) begin
                            state_q <= DONE;
                        end else begin
                            state_q <= EXEC;
                        end
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Status and counter-pin decode from the registered state
    always_comb begin
        busy    = (state_q != IDLE);
        done    = (state_q == DONE);
        done_id = (state_q == DONE) ? id_q : 3'd0;
        err     = (state_q == DONE) && err_q;
        result  = cnt_data_out;
        if ((state_q == EXEC) && (op_q == OP_LOAD)) begin
            cnt_load    = 1'b1;
            cnt_mode    = 1'b0;
            cnt_data_in = val_q;
        end else if (state_q == EXEC) begin
            cnt_load    = 1'b0;
            cnt_mode    = (op_q == OP_UP);
            cnt_data_in = cnt_data_out;
        end else begin
            cnt_load    = 1'b1;
            cnt_mode    = 1'b0;
            cnt_data_in = cnt_data_out;
        end
    end

endmodule

// File: tb/tb_mod10_counter_arbiter.sv
// Scoreboard bench for mod10_counter_arbiter with a behavioural mod-10 counter attached to its pins.
module tb_mod10_counter_arbiter;

    localparam int NUM_REQ = 4;
    localparam int STEP_W  = 8;

    logic                       clock = 1'b0;
    logic                       rst;
    logic                       cnt_rst_n;
    logic [NUM_REQ-1:0]         req;
    logic [2*NUM_REQ-1:0]       req_op;
    logic [4*NUM_REQ-1:0]       req_val;
    logic [STEP_W*NUM_REQ-1:0]  req_steps;
    logic [NUM_REQ-1:0]         gnt;
    logic                       busy, done, err, cnt_mode, cnt_load;
    logic [2:0]                 done_id;
    logic [3:0]                 result, cnt_data_in, cnt_data_out, cnt_q;

    typedef struct { int id; int res; int err; int lat; } exp_t;
    typedef struct { int id; int gap; } gexp_t;
    exp_t  sb_q[$];
    gexp_t gq[$];

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int last_gnt_cyc = 0;
    int mon_gi;
    exp_t  mon_e;
    gexp_t mon_g;

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    mod10_counter_arbiter #(.NUM_REQ(NUM_REQ), .STEP_W(STEP_W)) dut (
        .clock(clock), .rst(rst), .req(req), .req_op(req_op), .req_val(req_val),
        .req_steps(req_steps), .gnt(gnt), .busy(busy), .done(done), .done_id(done_id),
        .result(result), .err(err), .cnt_mode(cnt_mode), .cnt_load(cnt_load),
        .cnt_data_in(cnt_data_in), .cnt_data_out(cnt_data_out)
    );

    // Reference mod-10 counter with its own reset
    always @(posedge clock or negedge cnt_rst_n) begin
        if (!cnt_rst_n)    cnt_q <= 4'd0;
        else if (cnt_load) cnt_q <= cnt_data_in;
        else if (cnt_mode) cnt_q <= (cnt_q == 4'd9) ? 4'd0 : cnt_q + 4'd1;
        else               cnt_q <= (cnt_q == 4'd0) ? 4'd9 : cnt_q - 4'd1;
    end
    assign cnt_data_out = cnt_q;

    task automatic chk(input string nm, input int act, input int exp_v);
        n_vec++;
        if (act != exp_v) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp_v, cyc);
        end
    endtask

    // Monitor: pop expectations whenever the DUT grants or completes
    always @(negedge clock) begin
        if (rst) begin
            if (gnt != '0) begin
                mon_gi = -1;
                for (int i = 0; i < NUM_REQ; i++) if (gnt[i]) mon_gi = i;
                chk("gnt_onehot", $countones(gnt), 1);
                if (gq.size() == 0) begin
                    chk("gnt_unexpected", mon_gi, -1);
                end else begin
                    mon_g = gq.pop_front();
                    chk("gnt_id", mon_gi, mon_g.id);
                    if (mon_g.gap > 0) chk("gnt_gap", cyc - last_gnt_cyc, mon_g.gap);
                end
                last_gnt_cyc = cyc;
            end
            if (done) begin
                if (sb_q.size() == 0) begin
                    chk("done_unexpected", int'(done_id), -1);
                end else begin
                    mon_e = sb_q.pop_front();
                    chk("done_id", int'(done_id), mon_e.id);
                    chk("result", int'(result), mon_e.res);
                    chk("err", int'(err), mon_e.err);
                    chk("latency", cyc - last_gnt_cyc, mon_e.lat);
                end
            end
        end
    end

    task automatic wait_gnt(input int id);
        bit seen = 1'b0;
        for (int t = 0; t < 50 && !seen; t++) begin
            @(negedge clock);
            seen = gnt[id];
        end
        chk("gnt_wait", int'(seen), 1);
    endtask

    task automatic wait_drain();
        bit idle = 1'b0;
        for (int t = 0; t < 400 && !idle; t++) begin
            @(posedge clock);
            #1;
            idle = (sb_q.size() == 0) && !busy;
        end
        chk("drain", sb_q.size(), 0);
    endtask

    task automatic set_payload(input int id, input int op, input int val, input int steps);
        req_op[2*id +: 2]            = op[1:0];
        req_val[4*id +: 4]           = val[3:0];
        req_steps[STEP_W*id +: STEP_W] = steps[STEP_W-1:0];
    endtask

    task automatic issue(input int id, input int op, input int val, input int steps,
                         input int exp_res, input int exp_err, input int lat);
        exp_t  e;
        gexp_t g;
        set_payload(id, op, val, steps);
        e.id = id; e.res = exp_res; e.err = exp_err; e.lat = lat;
        g.id = id; g.gap = 0;
        sb_q.push_back(e);
        gq.push_back(g);
        req[id] = 1'b1;
        wait_gnt(id);
        @(posedge clock);
        #1 req[id] = 1'b0;
        if (op == 0 && val <= 9) begin
            @(negedge clock);
            chk("load_pin", int'(cnt_load), 1);
            chk("load_data", int'(cnt_data_in), val);
        end
        wait_drain();
    endtask

    // All requesters in mask issue READ together; grants expected in ascending order
    task automatic multi_read(input int mask, input int exp_res);
        exp_t  e;
        gexp_t g;
        int    pending;
        logic [NUM_REQ-1:0] gs;
        bit    first = 1'b1;
        pending = mask;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (mask[i]) begin
                set_payload(i, 3, 0, 0);
                e.id = i; e.res = exp_res; e.err = 0; e.lat = 1;
                g.id = i; g.gap = first ? 0 : 2;
                first = 1'b0;
                sb_q.push_back(e);
                gq.push_back(g);
            end
        end
        req = req | mask[NUM_REQ-1:0];
        for (int t = 0; t < 200 && pending != 0; t++) begin
            @(negedge clock);
            gs = gnt;
            @(posedge clock);
            #1;
            req = req & ~gs;
            pending = pending & ~int'(gs);
        end
        chk("multi_pending", pending, 0);
        wait_drain();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst = 1'b0; cnt_rst_n = 1'b0;
        req = '0; req_op = '0; req_val = '0; req_steps = '0;
        for (int t = 0; t < 3; t++) begin
            @(negedge clock);
            chk("rst_busy", int'(busy), 0);
            chk("rst_load", int'(cnt_load), 1);
            chk("rst_done", int'(done), 0);
        end
        @(posedge clock);
        #2 rst = 1'b1; cnt_rst_n = 1'b1;
        for (int t = 0; t < 20; t++) begin
            @(negedge clock);
            chk("idle_busy", int'(busy), 0);
            chk("idle_gnt", int'(gnt), 0);
            chk("idle_load", int'(cnt_load), 1);
            chk("idle_count", int'(cnt_data_out), 0);
        end
        @(posedge clock);
        #1;
        issue(0, 0, 7, 0, 7, 0, 2);      // LOAD 7
        issue(1, 1, 0, 5, 2, 0, 6);      // UP 5: 7 -> 2
        issue(2, 2, 0, 13, 9, 0, 14);    // DOWN 13: 2 -> 9
        issue(3, 1, 0, 0, 9, 0, 1);      // UP 0
        multi_read(15, 9);
        multi_read(5, 9);
        issue(1, 0, 4, 0, 4, 0, 2);      // LOAD 4
        issue(2, 0, 12, 0, 4, 1, 1);     // illegal LOAD 12
        chk("hold_after_err", int'(cnt_data_out), 4);

        // UP 200 from 4, interrupted by reset 50 edges after the grant cycle
        set_payload(1, 1, 0, 200);
        begin
            gexp_t g;
            g.id = 1; g.gap = 0;
            gq.push_back(g);
        end
        req[1] = 1'b1;
        wait_gnt(1);
        @(posedge clock);
        #1 req[1] = 1'b0;
        repeat (49) @(posedge clock);
        #3 rst = 1'b0;
        #1;
        chk("mid_busy", int'(busy), 0);
        chk("mid_done", int'(done), 0);
        chk("mid_gnt", int'(gnt), 0);
        chk("mid_done_id", int'(done_id), 0);
        chk("mid_err", int'(err), 0);
        chk("mid_load", int'(cnt_load), 1);
        chk("mid_mode", int'(cnt_mode), 0);
        chk("mid_count", int'(cnt_data_out), 3);
        chk("mid_data_in", int'(cnt_data_in), 3);
        repeat (2) @(posedge clock);
        #2 rst = 1'b1;
        repeat (4) @(negedge clock);
        chk("post_rst_count", int'(cnt_data_out), 3);
        @(posedge clock);
        #1;
        multi_read(5, 3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
